// File: rtl/fp_pkg.sv
// Shared float-format constants, status encoding and converter state codes.
// The float adder uses the same definitions.
package fp_pkg;

  localparam int DATA_W   = 32;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;
  localparam int EXP_MAX  = 63;

  // Field positions within a float word; bit 0 is the MSB
  localparam int SIGN_IDX = 0;
  localparam int EXP_HI   = 1;
  localparam int EXP_LO   = 6;
  localparam int FRAC_HI  = 7;
  localparam int FRAC_LO  = 31;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'd0,
    ST_OVERFLOW  = 4'd1,
    ST_UNDERFLOW = 4'd2,
    ST_INEXACT   = 4'd3
  } status_t;

  typedef logic [2:0] cvt_state_t;

  localparam cvt_state_t StIdle  = 3'd0;
  localparam cvt_state_t StAbs   = 3'd1;
  localparam cvt_state_t StNorm  = 3'd2;
  localparam cvt_state_t StRound = 3'd3;
  localparam cvt_state_t StPack  = 3'd4;

endpackage

// File: rtl/fp_int_to_float_if.sv
// Operand/result handshake bundle for the integer-to-float encoder.
interface fp_int_to_float_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [0:DATA_W-1] int_in;
  logic              out_valid;
  logic [0:DATA_W-1] data_out;
  logic [0:3]        status_out;

  modport master (
    output in_valid,
    output int_in,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  status_out
  );

  modport slave (
    input  in_valid,
    input  int_in,
    output in_ready,
    output out_valid,
    output data_out,
    output status_out
  );

endinterface

// File: rtl/fp_round_pack.sv
// Rounds a normalized magnitude and packs sign/exponent/fraction with status.
// FP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic              sign_i,
  input  logic [31:0]       mag_i,
  input  logic [4:0]        lz_i,
  input  logic              zero_i,
  output logic [0:DATA_W-1] data_o,
  output status_t           status_o
);

  logic [MAN_W-1:0] frac;
  logic [MAN_W-1:0] frac_r;
  logic             guard;
  logic             sticky;
  logic             carry;
  logic             is_zero;
  int               exp_s;

  always_comb begin
    frac    = mag_i[30:6];
    guard   = mag_i[5];
    sticky  = |mag_i[4:0];
    // A nonzero normalized magnitude always has its MSB set
    is_zero = zero_i | ~mag_i[31];
`ifdef FP_ROUND_NEAREST_EN
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
`else
    carry  = 1'b0;
    frac_r = frac;
`endif
    exp_s = 31 - int'(lz_i) - int'(FRAC_BITS) + EXP_BIAS + int'(carry);

    data_o   = '0;
    status_o = ST_EXACT;
    if (is_zero) begin
      status_o = ST_EXACT;
    end else if (exp_s >= EXP_MAX) begin
      data_o[SIGN_IDX]       = sign_i;
      data_o[EXP_HI:EXP_LO]  = EXP_W'(EXP_MAX);
      status_o               = ST_OVERFLOW;
    end else if (exp_s <= 0) begin
      data_o[SIGN_IDX]       = sign_i;
      status_o               = ST_UNDERFLOW;
    end else begin
      data_o[SIGN_IDX]       = sign_i;
      data_o[EXP_HI:EXP_LO]  = exp_s[EXP_W-1:0];
      data_o[FRAC_HI:FRAC_LO] = frac_r;
      status_o               = (guard | sticky) ? ST_INEXACT : ST_EXACT;
    end
  end

endmodule

// File: rtl/fp_int_to_float.sv
// Sequential signed fixed-point to custom float encoder; normalizes one bit per cycle.
// Rounding mode follows FP_ROUND_NEAREST_EN inside fp_round_pack.
module fp_int_to_float
  import fp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic               clock_100kHz,
  input  logic               reset,
  fp_int_to_float_if.slave   bus
);

  cvt_state_t        state_q, state_d;
  logic [31:0]       opnd_q, opnd_d;
  logic              sign_q, sign_d;
  logic [31:0]       mag_q, mag_d;
  logic [4:0]        lz_q, lz_d;
  logic              zero_q, zero_d;
  logic [0:DATA_W-1] data_q, data_d;
  status_t           status_q, status_d;
  logic              valid_q, valid_d;

  logic [31:0]       abs_mag;
  logic [0:DATA_W-1] pack_data;
  status_t           pack_status;

  assign abs_mag = opnd_q[31] ? (~opnd_q + 32'd1) : opnd_q;

  fp_round_pack #(
    .FRAC_BITS (FRAC_BITS)
  ) u_round_pack (
    .sign_i   (sign_q),
    .mag_i    (mag_q),
    .lz_i     (lz_q),
    .zero_i   (zero_q),
    .data_o   (pack_data),
    .status_o (pack_status)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    lz_d     = lz_q;
    zero_d   = zero_q;
    data_d   = data_q;
    status_d = status_q;
    valid_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          opnd_d  = bus.int_in;
          state_d = StAbs;
        end
      end
      StAbs: begin
        sign_d = opnd_q[31];
        mag_d  = abs_mag;
        lz_d   = '0;
        zero_d = (abs_mag == 32'd0);
        if (abs_mag == 32'd0)  state_d = StPack;
        else if (abs_mag[31])  state_d = StRound;
        else                   state_d = StNorm;
      end
      StNorm: begin
        mag_d = {mag_q[30:0], 1'b0};
        lz_d  = lz_q + 5'd1;
        // Leave once the shifted value will carry a leading one
        if (mag_q[30]) state_d = StRound;
      end
      StRound: begin
        state_d = StPack;
      end
      StPack: begin
        data_d   = pack_data;
        status_d = pack_status;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      opnd_q   <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      lz_q     <= '0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      status_q <= ST_EXACT;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      lz_q     <= lz_d;
      zero_q   <= zero_d;
      data_q   <= data_d;
      status_q <= status_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = valid_q;
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_fp_int_to_float.sv
// Randomized and directed bench for fp_int_to_float against an arithmetic reference model.
module tb_fp_int_to_float;

  logic clock_100kHz = 1'b0;
  logic reset        = 1'b0;
  int   n_cmp        = 0;
  int   n_fail       = 0;

  always #5 clock_100kHz = ~clock_100kHz;

  fp_int_to_float_if if0 ();
  fp_int_to_float_if if31 ();

  fp_int_to_float #(
    .FRAC_BITS (0)
  ) dut (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .bus          (if0.slave)
  );

  fp_int_to_float #(
    .FRAC_BITS (31)
  ) dut31 (
    .clock_100kHz (clock_100kHz),
    .reset        (reset),
    .bus          (if31.slave)
  );

  // Value-level reference: exact quotient/remainder rounding of |x| * 2^-fb
  task automatic model(input logic [31:0] x, input int fb, output logic [31:0] d,
                       output logic [3:0] st, output int lat);
    longint mag, q, rem, div;
    int     p, e;
    mag = x[31] ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
    d   = '0;
    st  = 4'd0;
    if (mag == 0) begin
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 33; i++) if (mag >= (longint'(1) << i)) p = i;
    if (p >= 25) begin
      div = longint'(1) << (p - 25);
      q   = mag / div;
      rem = mag % div;
    end else begin
      div = 1;
      q   = mag * (longint'(1) << (25 - p));
      rem = 0;
    end
    e = p - fb + 31;
`ifdef FP_ROUND_NEAREST_EN
    if ((2 * rem > div) || ((2 * rem == div) && (q % 2 == 1))) q = q + 1;
    if (q == (longint'(1) << 26)) begin
      q = longint'(1) << 25;
      e = e + 1;
    end
`endif
    if (e >= 63) begin
      d  = {x[31], 6'd63, 25'd0};
      st = 4'd1;
    end else if (e <= 0) begin
      d  = {x[31], 31'd0};
      st = 4'd2;
    end else begin
      d  = {x[31], e[5:0], q[24:0]};
      st = (rem != 0) ? 4'd3 : 4'd0;
    end
    lat = (31 - p) + 3;
  endtask

  task automatic drive_in(input bit use31, input logic v, input logic [31:0] x);
    if (use31) begin
      if31.in_valid = v;
      if31.int_in   = x;
    end else begin
      if0.in_valid = v;
      if0.int_in   = x;
    end
  endtask

  // Accepts x, then counts edges to out_valid; cyc = -1 when the budget expires
  task automatic convert(input bit use31, input logic [31:0] x, input bit hold,
                         output logic [31:0] d, output logic [3:0] st, output int cyc);
    int n;
    bit done;
    n    = 0;
    done = 0;
    cyc  = -1;
    d    = 'x;
    st   = 'x;
    drive_in(use31, 1'b1, x);
    @(posedge clock_100kHz); #1;
    drive_in(use31, hold, ~x);
    while (!done && n < 80) begin
      @(posedge clock_100kHz); #1;
      n++;
      if (use31 ? if31.out_valid : if0.out_valid) begin
        done = 1;
        cyc  = n;
        d    = use31 ? if31.data_out : if0.data_out;
        st   = use31 ? if31.status_out : if0.status_out;
      end
    end
    drive_in(use31, 1'b0, x);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid);
    end
    n_cmp++;
    if (if0.data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000000", if0.data_out);
    end
    n_cmp++;
    if (if0.status_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_status: got %0d want 0", if0.status_out);
    end
    n_cmp++;
    if (if0.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vin  [5];
    logic [31:0] vexp [5];
    int          vlat [5];
    logic [31:0] d;
    logic [3:0]  st;
    int          cyc;
    vin[0] = 32'h0000_0001; vexp[0] = 32'h3E00_0000; vlat[0] = 34;
    vin[1] = 32'hFFFF_FFFD; vexp[1] = 32'hC100_0000; vlat[1] = 33;
    vin[2] = 32'h8000_0000; vexp[2] = 32'hFC00_0000; vlat[2] = 3;
    vin[3] = 32'h0000_0000; vexp[3] = 32'h0000_0000; vlat[3] = 2;
`ifdef FP_ROUND_NEAREST_EN
    vin[4] = 32'h7FFF_FFFF; vexp[4] = 32'h7C00_0000; vlat[4] = 4;
`else
    vin[4] = 32'h7FFF_FFFF; vexp[4] = 32'h7BFF_FFFF; vlat[4] = 4;
`endif
    for (int i = 0; i < 5; i++) begin
      convert(1'b0, vin[i], 1'b0, d, st, cyc);
      n_cmp++;
      if (d !== vexp[i]) begin
        n_fail++; $display("FAIL directed_data[%h]: got %h want %h", vin[i], d, vexp[i]);
      end
      n_cmp++;
      if (st !== ((i == 4) ? 4'd3 : 4'd0)) begin
        n_fail++; $display("FAIL directed_status[%h]: got %0d want %0d", vin[i], st,
                           (i == 4) ? 3 : 0);
      end
      n_cmp++;
      if (cyc !== vlat[i]) begin
        n_fail++; $display("FAIL directed_latency[%h]: got %0d want %0d", vin[i], cyc, vlat[i]);
      end
    end
  endtask

  task automatic test_random(input bit use31, input int count);
    logic [31:0] x, d, md;
    logic [3:0]  st, mst;
    int          cyc, mlat;
    for (int i = 0; i < count; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      model(x, use31 ? 31 : 0, md, mst, mlat);
      convert(use31, x, 1'b0, d, st, cyc);
      n_cmp++;
      if (d !== md) begin
        n_fail++; $display("FAIL random_data[%h fb%0d]: got %h want %h", x, use31 ? 31 : 0, d, md);
      end
      n_cmp++;
      if (st !== mst) begin
        n_fail++; $display("FAIL random_status[%h]: got %0d want %0d", x, st, mst);
      end
      n_cmp++;
      if (cyc !== mlat) begin
        n_fail++; $display("FAIL random_latency[%h]: got %0d want %0d", x, cyc, mlat);
      end
    end
  endtask

  task automatic test_frac31();
    logic [31:0] d;
    logic [3:0]  st;
    int          cyc;
    convert(1'b1, 32'h1, 1'b0, d, st, cyc);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL frac31_data: got %h want 00000000", d);
    end
    n_cmp++;
    if (st !== 4'd2) begin
      n_fail++; $display("FAIL frac31_status: got %0d want 2", st);
    end
    test_random(1'b1, 12);
  endtask

  task automatic test_no_recapture();
    logic [31:0] x, d, md;
    logic [3:0]  st, mst;
    int          cyc, mlat;
    for (int i = 0; i < 4; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      model(x, 0, md, mst, mlat);
      convert(1'b0, x, 1'b1, d, st, cyc);
      n_cmp++;
      if (d !== md || st !== mst || cyc !== mlat) begin
        n_fail++; $display("FAIL busy_hold[%h]: got %h/%0d/%0d want %h/%0d/%0d", x, d, st, cyc,
                           md, mst, mlat);
      end
      @(posedge clock_100kHz); #1;
      n_cmp++;
      if (if0.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL busy_hold_pulse: got out_valid %b want 0", if0.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit done;
    logic [31:0] d;
    logic [3:0]  st;
    int          cyc;
    convert(1'b0, 32'h0, 1'b0, d, st, cyc);
    n_cmp++;
    if (cyc !== 2 || if0.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got lat %0d ready %b want 2 and 1", cyc, if0.in_ready);
    end
    // Present the next operand in the out_valid cycle itself
    drive_in(1'b0, 1'b1, 32'h1);
    @(posedge clock_100kHz); #1;
    drive_in(1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (if0.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got in_ready %b want 0", if0.in_ready);
    end
    n    = 0;
    done = 0;
    while (!done && n < 80) begin
      @(posedge clock_100kHz); #1;
      n++;
      if (if0.out_valid) done = 1;
    end
    n_cmp++;
    if (!done || n !== 34 || if0.data_out !== 32'h3E00_0000) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d data %h want 34 3e000000", done ? n : -1,
                         if0.data_out);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    drive_in(1'b0, 1'b1, 32'h1);
    @(posedge clock_100kHz); #1;
    drive_in(1'b0, 1'b1, 32'h5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock_100kHz); #1;
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (if0.data_out !== 32'h0 || if0.status_out !== 4'd0 || if0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: got %h/%0d/%b want 0/0/0", if0.data_out,
                         if0.status_out, if0.out_valid);
    end
    n_cmp++;
    if (if0.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_in_ready: got %b want 1", if0.in_ready);
    end
    drive_in(1'b0, 1'b0, 32'h0);
    @(negedge clock_100kHz);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock_100kHz); #1;
      if (if0.out_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_in(1'b0, 1'b0, 32'h0);
    drive_in(1'b1, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clock_100kHz);
    #1;
    test_reset();
    @(negedge clock_100kHz);
    reset = 1'b1;
    @(posedge clock_100kHz); #1;
    test_directed();
    test_no_recapture();
    test_random(1'b0, 30);
    test_frac31();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_int_to_float.md
Name: fp_int_to_float

Overview:
- Sequential encoder: converts a signed 32-bit fixed-point/integer operand into the team's custom 32-bit float format.
- Format: sign bit, 6-bit exponent (bias 31), 25-bit fraction with hidden 1; bit 0 is the MSB.
- This is the writer end of the float adder path: it produces the operands the adder consumes and reports status in the adder's status encoding.
- Normalizes one bit per cycle, then rounds and packs.

Parameters:
- FRAC_BITS, 0, number of fractional bits in int_in (0 = plain integer); legal range 0..31.

Ports:
- clock_100kHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  int_in is valid this cycle.
- in_ready  out  1  block can accept; high only in IDLE.
- int_in  in  [0:31]  two's-complement operand, bit 0 = MSB.
- out_valid  out  1  one-cycle pulse: data_out/status_out are new.
- data_out  out  [0:31]  float result: [0] sign, [1:6] biased exponent, [7:31] fraction.
- status_out  out  [0:3]  0 exact, 1 overflow, 2 underflow, 3 inexact; held until the next result.

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clock_100kHz.
  - Reset values: state IDLE, data_out=0, status_out=0, out_valid=0, all internal registers 0.
  - Reset mid-operation aborts the conversion; no out_valid is produced.
- Accept: on an edge with in_valid && in_ready, capture int_in and go to ABS. in_valid while busy is ignored.
- ABS: sign = int_in[0]; mag = |int_in| as 32-bit unsigned (-2^31 gives 0x80000000).
  - mag==0 -> PACK with zero result.
  - mag MSB already 1 -> ROUND.
  - otherwise -> NORM.
- NORM: mag <<= 1 and L += 1 each cycle until the MSB is 1; L = leading zeros, 0..31.
- ROUND:
  - Fields: fraction = mag bits below the MSB (25 bits); guard = next bit; sticky = OR of the remaining 5 bits.
  - Round to nearest, ties to even: increment fraction if guard && (sticky || fraction LSB).
  - A fraction carry-out sets fraction=0 and carry=1.
  - E = 31 - L - FRAC_BITS + 31 + carry, computed signed, at least 8 bits wide.
- PACK (registered outputs on leaving PACK, out_valid=1 for one cycle):
  - Zero input: data_out=0, status 0.
  - E >= 63: data_out = {sign, 6'd63, 0}, status 1.
  - E <= 0: data_out = {sign, 0, 0}, status 2.
  - guard|sticky: data_out = {sign, E[5:0], fraction}, status 3.
  - Otherwise: same packing, status 0.
- Latency from the accept edge: out_valid rises on edge L+3 for nonzero input, edge 2 for zero.
- Throughput: back-to-back is allowed; in_ready is high in the same cycle out_valid pulses.
- out_valid is never asserted without a preceding accept.

Optional Feature:
- Macro FP_ROUND_NEAREST_EN.
- Defined: round to nearest even as described above.
- Undefined: truncate (round toward zero), never increment, carry=0.
  - ROUND state still takes 1 cycle, so latency is identical.
  - Inexact status is still flagged from guard|sticky.

Decomposition:
- Package fp_pkg holds:
  - status_t enum: ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3.
  - Constants EXP_W=6, MAN_W=25, EXP_BIAS=31, EXP_MAX=63.
  - Field index constants.
  - State enum for this block.
  - These are shared with the adder.
- One sub-module, fp_round_pack: purely combinational; takes sign, normalized magnitude, L, zero flag; returns data_out value and status.

Test Plan:
- int_in=1 -> data_out=0x3E000000, status 0, out_valid on edge 34 after accept.
- int_in=-3 (0xFFFFFFFD) -> 0xC1000000, status 0; int_in=0x80000000 -> 0xFC000000, status 0, out_valid on edge 3.
- int_in=0x7FFFFFFF:
  - with FP_ROUND_NEAREST_EN -> 0x7C000000, status 3 (round carry into exponent).
  - without it -> 0x7BFFFFFF, status 3.
- int_in=0 -> data_out=0, status 0, out_valid on edge 2. Then a second operand (int_in=1) presented in the out_valid cycle is accepted in that same cycle.
- FRAC_BITS=31, int_in=1 -> data_out=0x00000000, status 2 (underflow).
- int_in=1, reset driven low 10 edges after accept -> outputs 0 immediately, in_ready=1, no out_valid pulse. in_valid held high during busy cycles causes no second capture.
